// File: rtl/status_flags.sv
// 6502 processor status register: N/V/D/I/Z/C flag storage, SO pin edge capture,
// PHP/BRK push byte generation and branch condition resolution.
module status_flags #(
   parameter int SO_SYNC   = 2,
   parameter bit D_RST_VAL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] alu_out,
   input  logic       alu_c,
   input  logic       alu_v,
   input  logic       upd_nz,
   input  logic       upd_c,
   input  logic       upd_v,
   input  logic       bit_op,
   input  logic [7:0] mem_data,
   input  logic       plp,
   input  logic [2:0] flag_op,
   input  logic       irq_set,
   input  logic       so_n,
   input  logic       brk_push,
   input  logic [2:0] br_sel,
   output logic [7:0] p_out,
   output logic [7:0] p_push,
   output logic       carry,
   output logic       br_taken
);

   localparam logic [2:0] FOP_SEC = 3'd1;
   localparam logic [2:0] FOP_CLC = 3'd2;
   localparam logic [2:0] FOP_SEI = 3'd3;
   localparam logic [2:0] FOP_CLI = 3'd4;
   localparam logic [2:0] FOP_SED = 3'd5;
   localparam logic [2:0] FOP_CLD = 3'd6;
   localparam logic [2:0] FOP_CLV = 3'd7;

   logic n_reg, n_next;
   logic v_reg, v_next;
   logic d_reg, d_next;
   logic i_reg, i_next;
   logic z_reg, z_next;
   logic c_reg, c_next;

   logic [SO_SYNC-1:0] so_sync_reg;
   logic [SO_SYNC-1:0] so_sync_next;
   logic               so_prev_reg;
   logic               so_level;
   logic               so_edge;

   logic op_sec, op_clc, op_sei, op_cli, op_sed, op_cld, op_clv;
   logic alu_zero;
   logic plp_unused;

   // PLP never loads the B and unused bit positions.
   assign plp_unused = ^mem_data[5:4];

   assign alu_zero = (alu_out == 8'h00);

   // so_n is asynchronous: shift it through SO_SYNC flops before edge detection.
   generate
      for (genvar gi = 0; gi < SO_SYNC; gi++) begin : g_so_sync
         if (gi == 0) begin : g_first
            assign so_sync_next[gi] = so_n;
         end else begin : g_rest
            assign so_sync_next[gi] = so_sync_reg[gi-1];
         end
      end
   endgenerate

   assign so_level = so_sync_reg[SO_SYNC-1];
   assign so_edge  = so_prev_reg & ~so_level;

   always_ff @(posedge clk) begin
      if (rst) begin
         so_sync_reg <= '1;
         so_prev_reg <= 1'b1;
      end else begin
         so_sync_reg <= so_sync_next;
         so_prev_reg <= so_level;
      end
   end

   always_comb begin
      op_sec = 1'b0;
      op_clc = 1'b0;
      op_sei = 1'b0;
      op_cli = 1'b0;
      op_sed = 1'b0;
      op_cld = 1'b0;
      op_clv = 1'b0;
      case (flag_op)
         FOP_SEC: op_sec = 1'b1;
         FOP_CLC: op_clc = 1'b1;
         FOP_SEI: op_sei = 1'b1;
         FOP_CLI: op_cli = 1'b1;
         FOP_SED: op_sed = 1'b1;
         FOP_CLD: op_cld = 1'b1;
         FOP_CLV: op_clv = 1'b1;
         default: ;
      endcase
   end

   // Each flag resolves its own priority chain; PLP masks every lower source.
   always_comb begin
      n_next = n_reg;
      if (plp)
         n_next = mem_data[7];
      else if (bit_op)
         n_next = mem_data[7];
      else if (upd_nz)
         n_next = alu_out[7];
   end

   always_comb begin
      v_next = v_reg;
      if (so_edge)
         v_next = 1'b1;
      else if (plp)
         v_next = mem_data[6];
      else if (op_clv)
         v_next = 1'b0;
      else if (bit_op)
         v_next = mem_data[6];
      else if (upd_v)
         v_next = alu_v;
   end

   always_comb begin
      d_next = d_reg;
      if (plp)
         d_next = mem_data[3];
      else if (op_sed)
         d_next = 1'b1;
      else if (op_cld)
         d_next = 1'b0;
   end

   always_comb begin
      i_next = i_reg;
      if (irq_set)
         i_next = 1'b1;
      else if (plp)
         i_next = mem_data[2];
      else if (op_sei)
         i_next = 1'b1;
      else if (op_cli)
         i_next = 1'b0;
   end

   always_comb begin
      z_next = z_reg;
      if (plp)
         z_next = mem_data[1];
      else if (bit_op || upd_nz)
         z_next = alu_zero;
   end

   always_comb begin
      c_next = c_reg;
      if (plp)
         c_next = mem_data[0];
      else if (op_sec)
         c_next = 1'b1;
      else if (op_clc)
         c_next = 1'b0;
      else if (upd_c)
         c_next = alu_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_reg <= 1'b0;
         v_reg <= 1'b0;
         d_reg <= D_RST_VAL;
         i_reg <= 1'b1;
         z_reg <= 1'b0;
         c_reg <= 1'b0;
      end else begin
         n_reg <= n_next;
         v_reg <= v_next;
         d_reg <= d_next;
         i_reg <= i_next;
         z_reg <= z_next;
         c_reg <= c_next;
      end
   end

   assign p_out  = {n_reg, v_reg, 1'b1, 1'b1, d_reg, i_reg, z_reg, c_reg};
   assign p_push = {n_reg, v_reg, 1'b1, brk_push, d_reg, i_reg, z_reg, c_reg};
   assign carry  = c_reg;

   always_comb begin
      logic flag_sel;
      flag_sel = 1'b0;
      case (br_sel[2:1])
         2'd0: flag_sel = n_reg;
         2'd1: flag_sel = v_reg;
         2'd2: flag_sel = c_reg;
         2'd3: flag_sel = z_reg;
         default: flag_sel = 1'b0;
      endcase
      br_taken = (flag_sel == br_sel[0]);
   end

endmodule
